// File: rtl/led_rate_mon.sv
// Measures the half-period of a blinking LED and reports CNT_1S / half-period as a blink divider.
// Results appear 29 cycles after each measuring edge; no flow control, and a stuck LED is flagged after TIMEOUT idle cycles.
module led_rate_mon #(
  parameter int CNT_1S  = 100000000,
  parameter int TIMEOUT = 200000000,
  parameter int DIV_MAX = 20
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        led_i,
  output logic [27:0] period_o,
  output logic [4:0]  div_o,
  output logic        valid_o,
  output logic        range_o,
  output logic        stuck_o,
  output logic        led_lvl_o
);

  localparam logic [27:0] CNT_C  = 28'(CNT_1S);
  localparam logic [27:0] TO_C   = 28'(TIMEOUT);
  localparam logic [27:0] DMAX_C = 28'(DIV_MAX);

  typedef enum logic [1:0] {SYNC, MEASURE, DIVIDE} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [27:0] cnt_q, cnt_d;
  logic [27:0] period_q, period_d;
  logic [4:0]  div_q, div_d;
  logic        valid_q, valid_d;
  logic        range_q, range_d;
  logic        stuck_q, stuck_d;
  logic [27:0] rem_q, rem_d;
  logic [27:0] quo_q, quo_d;
  logic [4:0]  step_q, step_d;
  logic        zero_q, zero_d;

  logic        edge_pulse;
  logic        cnt_sat;
  logic [28:0] rem_shift;
  logic [28:0] diff;
  logic        ge;
  logic [27:0] quo_next;
  logic [27:0] rem_next;

  assign edge_pulse = sync2_q ^ prev_q;
  assign cnt_sat    = (cnt_q == TO_C);

  // One restoring-division step: the dividend bits are shifted out of quo_q as quotient bits shift in.
  assign rem_shift = {rem_q, quo_q[27]};
  assign diff      = rem_shift - {1'b0, period_q};
  assign ge        = ~diff[28];
  assign quo_next  = {quo_q[26:0], ge};
  assign rem_next  = ge ? diff[27:0] : rem_shift[27:0];

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    div_d    = div_q;
    valid_d  = 1'b0;
    range_d  = range_q;
    stuck_d  = stuck_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    zero_d   = zero_q;
    cnt_d    = edge_pulse ? 28'd0 : (cnt_sat ? cnt_q : cnt_q + 28'd1);

    case (state_q)
      SYNC: begin
        if (edge_pulse) begin
          state_d = MEASURE;
          stuck_d = 1'b0;
        end else if (cnt_sat) begin
          stuck_d = 1'b1;
        end
      end
      MEASURE: begin
        if (edge_pulse) begin
          period_d = cnt_q;
          state_d  = DIVIDE;
          rem_d    = 28'd0;
          quo_d    = CNT_C;
          step_d   = 5'd0;
          zero_d   = (cnt_q == 28'd0);
        end else if (cnt_sat) begin
          stuck_d = 1'b1;
          state_d = SYNC;
        end
      end
      DIVIDE: begin
        // Edges and timeouts are deliberately ignored here; cnt keeps tracking on its own.
        rem_d  = rem_next;
        quo_d  = quo_next;
        step_d = step_q + 5'd1;
        if (step_q == 5'd27) begin
          state_d = MEASURE;
          valid_d = 1'b1;
          if (zero_q) begin
            div_d   = 5'd31;
            range_d = 1'b1;
          end else begin
            div_d   = (|quo_next[27:5]) ? 5'd31 : quo_next[4:0];
            range_d = (quo_next == 28'd0) || (quo_next > DMAX_C);
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= 28'd0;
      state_q  <= SYNC;
      period_q <= 28'd0;
      div_q    <= 5'd0;
      valid_q  <= 1'b0;
      range_q  <= 1'b0;
      stuck_q  <= 1'b0;
      rem_q    <= 28'd0;
      quo_q    <= 28'd0;
      step_q   <= 5'd0;
      zero_q   <= 1'b0;
    end else begin
      sync1_q  <= led_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      period_q <= period_d;
      div_q    <= div_d;
      valid_q  <= valid_d;
      range_q  <= range_d;
      stuck_q  <= stuck_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      zero_q   <= zero_d;
    end
  end

  assign period_o  = period_q;
  assign div_o     = div_q;
  assign valid_o   = valid_q;
  assign range_o   = range_q;
  assign stuck_o   = stuck_q;
  assign led_lvl_o = sync2_q;

endmodule
